// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states,
// stream geometry constants and the word-address helper.
package imem_loader_pkg;

  // Bytes per instruction word and per length header.
  localparam int WORD_BYTES = 4;
  localparam int LEN_BYTES  = 2;

  // Loader FSM states. DONE and ERR are terminal until reset.
  typedef enum logic [2:0] {
    LEN0  = 3'd0,
    LEN1  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  // Byte address of word idx relative to base, modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [15:0] idx);
    return base + {14'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and RAM write port of the loader, bundled together.
//
// Handshake: a byte transfers on every rising clk edge where both
// byte_valid and byte_ready are high; byte_data is ignored otherwise.
// The source may hold byte_valid low for any number of cycles. byte_ready
// depends only on loader state, never on byte_valid. mem_we is a one-cycle
// strobe with no back-pressure; mem_addr/mem_wdata are valid while it is high.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  // Host / byte source side (also sees the RAM write port).
  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side.
  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian word assembler: the first byte of a word lands in [7:0],
// the last in [31:24]. word_done_o flags the shift that completes a word;
// the byte counter then wraps to 0 ready for the next word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        shift_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  localparam int CNT_W = $clog2(WORD_BYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_BYTES - 1);

  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]      word_q, word_d;

  // Place the incoming byte at its lane and advance the lane counter.
  always_comb begin
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    if (shift_en_i) begin
      word_d[{byte_cnt_q, 3'b000} +: 8] = byte_i;
      byte_cnt_d                        = byte_cnt_q + 1'b1;
    end
  end

  // Assembly register and lane counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q     <= '0;
      byte_cnt_q <= '0;
    end else begin
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign word_o      = word_q;
  assign word_done_o = shift_en_i && (byte_cnt_q == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a 16-bit little-endian word count,
// packs the following bytes into words and writes them to consecutive
// word addresses starting at BASE_ADDR, holding the CPU in reset until the
// load has finished. An oversized count parks the loader in ERR.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         error,
  output state_t       dbg_state_o
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);

  state_t      state_q, state_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [31:0] addr_q, addr_d;

  logic        accept;
  logic        shift_en;
  logic        word_done;
  logic [31:0] packed_word;
  logic [15:0] hdr_len;

  assign bus.byte_ready = (state_q == LEN0) || (state_q == LEN1) ||
                          (state_q == DATA);
  assign accept   = bus.byte_valid && bus.byte_ready;
  assign shift_en = accept && (state_q == DATA);
  assign hdr_len  = {bus.byte_data, len_lo_q};

  byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .shift_en_i  (shift_en),
    .byte_i      (bus.byte_data),
    .word_o      (packed_word),
    .word_done_o (word_done)
  );

  // Next-state logic: header parse, word collection, write bubble.
  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      LEN0: begin
        if (accept) begin
          len_lo_d = bus.byte_data;
          state_d  = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          len_d = hdr_len;
          if (hdr_len == 16'd0) begin
            state_d = DONE;
          end else if ({16'h0000, hdr_len} > DEPTH_W) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (word_done) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (word_cnt_q == (len_q - 16'd1)) begin
          state_d = DONE;
        end else begin
          word_cnt_d = word_cnt_q + 16'd1;
          state_d    = DATA;
        end
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = LEN0;
    endcase
  end

  // Write address tracks the word counter so it is settled by WRITE.
  always_comb begin
    addr_d = word_addr(BASE_ADDR, word_cnt_d);
  end

  // State, header and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LEN0;
      len_lo_q   <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      addr_q     <= BASE_ADDR;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
    end
  end

  assign bus.mem_we    = (state_q == WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = packed_word;

  assign cpu_hold    = (state_q != DONE);
  assign done        = (state_q == DONE);
  assign error       = (state_q == ERR);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a default-parameter instance (A) and a small
// DEPTH_WORDS=4 / BASE_ADDR=0x100 instance (B) share one byte driver,
// steered by sel. Expected writes go into exp_q; a negedge monitor pops
// and compares every mem_we pulse of the selected instance.
module tb_imem_loader;
  import imem_loader_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  // ---------------- DUTs ----------------
  logic       drv_valid = 1'b0;
  logic [7:0] drv_data  = 8'h00;
  logic       sel       = 1'b0;

  imem_loader_if if_a ();
  imem_loader_if if_b ();

  assign if_a.byte_valid = drv_valid & ~sel;
  assign if_a.byte_data  = drv_data;
  assign if_b.byte_valid = drv_valid & sel;
  assign if_b.byte_data  = drv_data;

  logic   cpu_hold_a, done_a, error_a;
  logic   cpu_hold_b, done_b, error_b;
  state_t st_a, st_b;

  imem_loader #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a),
    .cpu_hold(cpu_hold_a), .done(done_a), .error(error_a), .dbg_state_o(st_a)
  );

  imem_loader #(.DEPTH_WORDS(4), .BASE_ADDR(32'h0000_0100)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b),
    .cpu_hold(cpu_hold_b), .done(done_b), .error(error_b), .dbg_state_o(st_b)
  );

  logic        obs_ready, obs_we, obs_hold, obs_done, obs_error;
  logic [31:0] obs_addr, obs_wdata;
  state_t      obs_st;
  assign obs_ready = sel ? if_b.byte_ready : if_a.byte_ready;
  assign obs_we    = sel ? if_b.mem_we     : if_a.mem_we;
  assign obs_addr  = sel ? if_b.mem_addr   : if_a.mem_addr;
  assign obs_wdata = sel ? if_b.mem_wdata  : if_a.mem_wdata;
  assign obs_hold  = sel ? cpu_hold_b      : cpu_hold_a;
  assign obs_done  = sel ? done_b          : done_a;
  assign obs_error = sel ? error_b         : error_a;
  assign obs_st    = sel ? st_b            : st_a;

  // ---------------- scoreboard ----------------
  int          tests_run = 0;
  int          fails     = 0;
  logic [63:0] exp_q[$];

  always @(negedge clk) begin
    if (obs_we === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL spurious_write: got addr=%h data=%h, required no write",
                 obs_addr, obs_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({obs_addr, obs_wdata} !== e)
          begin
            fails++;
            $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                     obs_addr, obs_wdata, e[63:32], e[31:0]);
          end
      end
      tests_run++;
      if (obs_ready !== 1'b0) begin
        fails++;
        $display("FAIL ready_in_write: got %b, required 0", obs_ready);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst       = 1'b1;
    drv_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t         = 0;
    drv_valid = 1'b1;
    drv_data  = b;
    while (obs_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      tests_run++;
      fails++;
      $display("FAIL send_timeout: byte_ready stayed %b, required 1", obs_ready);
      drv_valid = 1'b0;
    end else begin
      @(negedge clk);
      drv_valid = 1'b0;
    end
  endtask

  task automatic send_gap(input logic [7:0] b, input int gap);
    drv_valid = 1'b0;
    repeat (gap) @(negedge clk);
    send_byte(b);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    tests_run++;
    if (st_a !== LEN0) begin fails++; $display("FAIL reset_state: got %0d, required %0d", st_a, LEN0); end
    tests_run++;
    if (if_a.byte_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b, required 1", if_a.byte_ready); end
    tests_run++;
    if (if_a.mem_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b, required 0", if_a.mem_we); end
    tests_run++;
    if (if_a.mem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h, required 0", if_a.mem_addr); end
    tests_run++;
    if (if_a.mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata: got %h, required 0", if_a.mem_wdata); end
    tests_run++;
    if ({cpu_hold_a, done_a, error_a} !== 3'b100) begin
      fails++; $display("FAIL reset_flags: got hold/done/err=%b, required 100", {cpu_hold_a, done_a, error_a});
    end
    tests_run++;
    if (if_b.mem_addr !== 32'h100) begin fails++; $display("FAIL reset_addr_base: got %h, required 100", if_b.mem_addr); end
  endtask

  task automatic test_two_words();
    logic [7:0] s [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                           8'h93, 8'h00, 8'h10, 8'h00};
    sel = 1'b0;
    do_reset();
    exp_q.push_back({32'h0000_0000, 32'h0000_0013});
    exp_q.push_back({32'h0000_0004, 32'h0010_0093});
    for (int i = 0; i < 10; i++) send_byte(s[i]);
    // Now in the final WRITE cycle.
    tests_run++;
    if ({obs_hold, obs_done} !== 2'b10) begin
      fails++; $display("FAIL two_words_write_flags: got hold/done=%b, required 10", {obs_hold, obs_done});
    end
    @(negedge clk);
    tests_run++;
    if ({obs_hold, obs_done, obs_error} !== 3'b010) begin
      fails++; $display("FAIL two_words_done: got hold/done/err=%b, required 010", {obs_hold, obs_done, obs_error});
    end
    tests_run++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL two_words_count: %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_zero_len();
    sel = 1'b0;
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    tests_run++;
    if ({obs_hold, obs_done, obs_ready} !== 3'b010) begin
      fails++; $display("FAIL zero_len_done: got hold/done/ready=%b, required 010", {obs_hold, obs_done, obs_ready});
    end
    drv_valid = 1'b1;
    drv_data  = 8'h55;
    repeat (4) @(negedge clk);
    drv_valid = 1'b0;
    tests_run++;
    if (obs_st !== DONE) begin fails++; $display("FAIL zero_len_stays: got state %0d, required %0d", obs_st, DONE); end
  endtask

  task automatic test_error();
    sel = 1'b1;
    do_reset();
    send_byte(8'h05);
    send_byte(8'h00);
    tests_run++;
    if ({obs_error, obs_ready, obs_hold, obs_done} !== 4'b1010) begin
      fails++; $display("FAIL error_flags: got err/ready/hold/done=%b, required 1010",
                        {obs_error, obs_ready, obs_hold, obs_done});
    end
    drv_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drv_data = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    drv_valid = 1'b0;
    tests_run++;
    if ({obs_st, obs_error, obs_ready} !== {ERR, 1'b1, 1'b0}) begin
      fails++; $display("FAIL error_sticky: got state=%0d err=%b ready=%b, required state=%0d err=1 ready=0",
                        obs_st, obs_error, obs_ready, ERR);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] b [12];
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) b[i] = 8'($urandom_range(0, 255));
    for (int w = 0; w < 3; w++)
      exp_q.push_back({32'(4 * w), b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]});
    send_gap(8'h03, $urandom_range(1, 7));
    send_gap(8'h00, $urandom_range(1, 7));
    for (int i = 0; i < 12; i++) send_gap(b[i], $urandom_range(1, 7));
    @(negedge clk);
    tests_run++;
    if ({obs_hold, obs_done} !== 2'b01) begin
      fails++; $display("FAIL gaps_done: got hold/done=%b, required 01", {obs_hold, obs_done});
    end
    tests_run++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL gaps_count: %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] s1 [8] = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
    logic [7:0] s2 [6] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    sel = 1'b0;
    do_reset();
    exp_q.push_back({32'h0, 32'h4433_2211});
    for (int i = 0; i < 8; i++) send_byte(s1[i]);
    do_reset();
    tests_run++;
    if ({obs_st, obs_ready, obs_hold, obs_done} !== {LEN0, 1'b1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL mid_reset_state: got state=%0d ready=%b hold=%b done=%b, required state=%0d ready=1 hold=1 done=0",
                        obs_st, obs_ready, obs_hold, obs_done, LEN0);
    end
    tests_run++;
    if ({obs_addr, obs_wdata} !== 64'h0) begin
      fails++; $display("FAIL mid_reset_regs: got addr=%h data=%h, required 0/0", obs_addr, obs_wdata);
    end
    tests_run++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL mid_reset_word0: %0d writes missing, required 0", exp_q.size()); end
    exp_q.push_back({32'h0, 32'hDEAD_BEEF});
    for (int i = 0; i < 6; i++) send_byte(s2[i]);
    @(negedge clk);
    tests_run++;
    if ({obs_hold, obs_done} !== 2'b01) begin
      fails++; $display("FAIL mid_reset_done: got hold/done=%b, required 01", {obs_hold, obs_done});
    end
    tests_run++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL mid_reset_count: %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_base_full();
    logic [7:0] b [16];
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) b[i] = 8'($urandom_range(0, 255));
    for (int w = 0; w < 4; w++)
      exp_q.push_back({32'h100 + 32'(4 * w), b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]});
    send_byte(8'h04);
    send_byte(8'h00);
    for (int i = 0; i < 16; i++) send_byte(b[i]);
    @(negedge clk);
    tests_run++;
    if ({obs_hold, obs_done, obs_error} !== 3'b010) begin
      fails++; $display("FAIL base_full_done: got hold/done/err=%b, required 010", {obs_hold, obs_done, obs_error});
    end
    tests_run++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL base_full_count: %0d writes missing, required 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_two_words();
    test_zero_len();
    test_error();
    test_gaps();
    test_mid_reset();
    test_base_full();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
